// File: rtl/decode_sched_pkg.sv
// Shared decode constants: RV32 opcodes, immediate-select codes and CSR funct3 fields.
package decode_sched_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Encoding shared with the immediate generator.
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_C = 3'b101
  } imm_sel_e;

  localparam logic [2:0] F3_PRIV        = 3'b000;
  localparam int         F3_CSR_IMM_BIT = 2;

  typedef struct packed {
    imm_sel_e imm_sel;
    logic     reg_wen;
    logic     mem_rd;
    logic     mem_wr;
    logic     branch;
    logic     jump;
    logic     csr_wen;
    logic     illegal;
  } dec_t;

endpackage

// File: rtl/decode_sched_dec.sv
// Combinational opcode decoder: immediate select, control flags and source-register usage.
// DECODE_SCHED_ILLEGAL_TRAP_EN enables illegal-opcode flagging; otherwise unknown opcodes are NOPs.
module decode_sched_dec
  import decode_sched_pkg::*;
(
  input  logic [14:0] inst,
  output dec_t        dec,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       rd_nz;
  dec_t       raw;
`ifdef DECODE_SCHED_ILLEGAL_TRAP_EN
  logic       known;
`endif

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign rd_nz = (inst[11:7] != 5'd0);

  always_comb begin
    raw         = '0;
    raw.imm_sel = IMM_I;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;
`ifdef DECODE_SCHED_ILLEGAL_TRAP_EN
    known       = 1'b1;
`endif
    case (opc)
      OPC_LOAD:   begin raw.reg_wen = 1'b1; raw.mem_rd = 1'b1; end
      OPC_OP_IMM: raw.reg_wen = 1'b1;
      OPC_OP:     begin raw.reg_wen = 1'b1; uses_rs2 = 1'b1; end
      OPC_STORE:  begin raw.imm_sel = IMM_S; raw.mem_wr = 1'b1; uses_rs2 = 1'b1; end
      OPC_BRANCH: begin raw.imm_sel = IMM_B; raw.branch = 1'b1; uses_rs2 = 1'b1; end
      OPC_JAL:    begin raw.imm_sel = IMM_J; raw.reg_wen = 1'b1; raw.jump = 1'b1; uses_rs1 = 1'b0; end
      OPC_JALR:   begin raw.reg_wen = 1'b1; raw.jump = 1'b1; end
      OPC_LUI,
      OPC_AUIPC:  begin raw.imm_sel = IMM_U; raw.reg_wen = 1'b1; uses_rs1 = 1'b0; end
      OPC_SYSTEM: begin
        raw.reg_wen = (f3 != F3_PRIV);
        raw.csr_wen = (f3 != F3_PRIV);
        if (f3[F3_CSR_IMM_BIT]) begin
          raw.imm_sel = IMM_C;
          uses_rs1    = 1'b0;
        end
      end
`ifdef DECODE_SCHED_ILLEGAL_TRAP_EN
      default:    known = 1'b0;
`else
      default:    ;
`endif
    endcase
    raw.reg_wen = raw.reg_wen & rd_nz;
`ifdef DECODE_SCHED_ILLEGAL_TRAP_EN
    if (!known || inst[1:0] != 2'b11) begin
      raw.reg_wen = 1'b0;
      raw.mem_rd  = 1'b0;
      raw.mem_wr  = 1'b0;
      raw.branch  = 1'b0;
      raw.jump    = 1'b0;
      raw.csr_wen = 1'b0;
      raw.illegal = 1'b1;
    end
`endif
    dec = raw;
  end

endmodule

// File: rtl/decode_sched.sv
// Decode-stage controller: valid/ready intake, single output register, load-use bubble, flush, stall counter.
// Illegal-opcode trapping is built in when DECODE_SCHED_ILLEGAL_TRAP_EN is defined.
module decode_sched
  import decode_sched_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [2:0]       out_imm_sel,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_reg_wen,
  output logic             out_mem_rd,
  output logic             out_mem_wr,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_csr_wen,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  dec_t       dec;
  logic       uses_rs1;
  logic       uses_rs2;
  logic [4:0] in_rs1;
  logic [4:0] in_rs2;
  logic       hazard;
  logic       accept;

  decode_sched_dec u_dec (
    .inst     (in_inst[14:0]),
    .dec      (dec),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign in_rs1 = in_inst[19:15];
  assign in_rs2 = in_inst[24:20];

  // A held load whose destination the incoming instruction reads must reach execute first.
  assign hazard = in_valid & out_valid & out_mem_rd & (out_rd != 5'd0) &
                  ((uses_rs1 & (in_rs1 == out_rd)) | (uses_rs2 & (in_rs2 == out_rd)));

  assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush & ~rst;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_inst    <= '0;
      out_imm_sel <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_reg_wen <= 1'b0;
      out_mem_rd  <= 1'b0;
      out_mem_wr  <= 1'b0;
      out_branch  <= 1'b0;
      out_jump    <= 1'b0;
      out_csr_wen <= 1'b0;
      out_illegal <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_inst    <= in_inst;
        out_imm_sel <= dec.imm_sel;
        out_rd      <= in_inst[11:7];
        out_rs1     <= in_rs1;
        out_rs2     <= in_rs2;
        out_reg_wen <= dec.reg_wen;
        out_mem_rd  <= dec.mem_rd;
        out_mem_wr  <= dec.mem_wr;
        out_branch  <= dec.branch;
        out_jump    <= dec.jump;
        out_csr_wen <= dec.csr_wen;
        out_illegal <= dec.illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid & hazard & ~flush & ~(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_decode_sched.sv
// Self-checking bench for decode_sched: spec-level model checked every cycle plus directed literal checks.
module tb_decode_sched;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [2:0]       out_imm_sel;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic             out_reg_wen, out_mem_rd, out_mem_wr, out_branch, out_jump, out_csr_wen;
  logic             out_illegal;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  decode_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_imm_sel(out_imm_sel), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_reg_wen(out_reg_wen), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_branch(out_branch), .out_jump(out_jump), .out_csr_wen(out_csr_wen),
    .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // flags = {reg_wen, mem_rd, mem_wr, branch, jump, csr_wen}
  typedef struct packed {
    logic [2:0] sel;
    logic [5:0] flags;
    logic       ill;
  } exp_t;

  function automatic exp_t ref_dec(input logic [31:0] i);
    exp_t       e;
    logic [6:0] o  = i[6:0];
    logic [2:0] f3 = i[14:12];
    bit         wr;
`ifdef DECODE_SCHED_ILLEGAL_TRAP_EN
    bit legal = o inside {7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
                          7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011};
`endif
    e = '0;
    if (o == 7'b0100011)                      e.sel = 3'd1;
    else if (o == 7'b1100011)                 e.sel = 3'd2;
    else if (o == 7'b1101111)                 e.sel = 3'd3;
    else if (o inside {7'b0110111, 7'b0010111}) e.sel = 3'd4;
    else if (o == 7'b1110011 && f3[2])        e.sel = 3'd5;
    wr = (o inside {7'b0000011, 7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
                    7'b1101111, 7'b1100111}) || (o == 7'b1110011 && f3 != 3'd0);
    e.flags = {wr && i[11:7] != 5'd0, o == 7'b0000011, o == 7'b0100011, o == 7'b1100011,
               o == 7'b1101111 || o == 7'b1100111, o == 7'b1110011 && f3 != 3'd0};
`ifdef DECODE_SCHED_ILLEGAL_TRAP_EN
    if (!legal || i[1:0] != 2'b11) begin
      e.flags = '0;
      e.ill   = 1'b1;
    end
`endif
    return e;
  endfunction

  function automatic bit m_uses_rs1(input logic [31:0] i);
    return !(i[6:0] == 7'b0110111 || i[6:0] == 7'b0010111 || i[6:0] == 7'b1101111 ||
             (i[6:0] == 7'b1110011 && i[14]));
  endfunction

  function automatic bit m_uses_rs2(input logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  // Model state: what the output register must hold, and the expected stall count.
  bit               m_valid = 1'b0;
  logic [31:0]      m_inst  = '0;
  logic [CNT_W-1:0] m_stall = '0;

  function automatic bit m_hazard();
    logic [4:0] hrd = m_inst[11:7];
    return in_valid && m_valid && m_inst[6:0] == 7'b0000011 && hrd != 5'd0 &&
           ((m_uses_rs1(in_inst) && in_inst[19:15] == hrd) ||
            (m_uses_rs2(in_inst) && in_inst[24:20] == hrd));
  endfunction

  function automatic bit m_ready();
    return (!m_valid || out_ready) && !m_hazard() && !flush && !rst;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_stall = '0;
    end else begin
      bit hz, rdy;
      hz  = m_hazard();
      rdy = m_ready();
      if (in_valid && hz && !flush && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1;
      if (flush) m_valid = 1'b0;
      else if (in_valid && rdy) begin
        m_valid = 1'b1;
        m_inst  = in_inst;
      end else if (out_ready) m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      e = ref_dec(m_inst);
      chk("in_ready", in_ready, m_ready());
      chk("out_valid", out_valid, m_valid);
      chk("stall_cnt", stall_cnt, m_stall);
      if (m_valid) begin
        chk("out_inst", out_inst, m_inst);
        chk("out_imm_sel", out_imm_sel, e.sel);
        chk("out_regs", {out_rd, out_rs1, out_rs2}, {m_inst[11:7], m_inst[19:15], m_inst[24:20]});
        chk("out_flags", {out_reg_wen, out_mem_rd, out_mem_wr, out_branch, out_jump, out_csr_wen}, e.flags);
        chk("out_illegal", out_illegal, e.ill);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  logic [31:0] sweep_inst [6] = '{32'h00500093, 32'h00112023, 32'h00208463,
                                  32'h008000EF, 32'h12345037, 32'h3400D073};
  logic [2:0]  sweep_sel  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [5:0]  sweep_flg  [6] = '{6'b100000, 6'b001000, 6'b000100, 6'b100010, 6'b000000, 6'b000001};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_stall_cnt", stall_cnt, '0);
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0; out_ready = 1'b1;

    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_inst  = sweep_inst[k];
      tick();
      chk("sweep_valid", out_valid, 1'b1);
      chk("sweep_sel", out_imm_sel, sweep_sel[k]);
      chk("sweep_flags", {out_reg_wen, out_mem_rd, out_mem_wr, out_branch, out_jump, out_csr_wen}, sweep_flg[k]);
    end

    // lw x5,0(x1) then add x6,x5,x2
    in_inst = 32'h0000A283;
    tick();
    chk("lu_load_held", out_valid, 1'b1);
    in_inst = 32'h00228333;
    #1 chk("lu_in_ready_hazard", in_ready, 1'b0);
    tick();
    chk("lu_bubble", out_valid, 1'b0);
    chk("lu_in_ready_after", in_ready, 1'b1);
    tick();
    chk("lu_consumer_valid", out_valid, 1'b1);
    chk("lu_consumer_inst", out_inst, 32'h00228333);
    chk("lu_stall_cnt", stall_cnt, 32'd1);

    // Same pair targeting x0: no bubble
    in_inst = 32'h0000A003;
    tick();
    in_inst = 32'h00200333;
    #1 chk("x0_in_ready", in_ready, 1'b1);
    tick();
    chk("x0_valid", out_valid, 1'b1);
    chk("x0_inst", out_inst, 32'h00200333);
    chk("x0_stall_cnt", stall_cnt, 32'd1);

    // Backpressure
    in_inst = 32'h00500093;
    tick();
    out_ready = 1'b0;
    in_inst   = 32'h00112023;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", in_ready, 1'b0);
      tick();
      chk("bp_hold_inst", out_inst, 32'h00500093);
      chk("bp_hold_sel", out_imm_sel, 3'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1'b1);
    tick();
    chk("bp_next_inst", out_inst, 32'h00112023);

    // Flush while holding and presenting
    out_ready = 1'b0;
    in_inst   = 32'h00208463;
    flush     = 1'b1;
    #1 chk("fl_in_ready", in_ready, 1'b0);
    tick();
    chk("fl_out_valid", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_dropped", out_valid, 1'b0);

    // Unlisted opcode
    in_valid = 1'b1; in_inst = 32'h0000007F;
    tick();
    in_valid = 1'b0;
    chk("ill_flags", {out_reg_wen, out_mem_rd, out_mem_wr, out_branch, out_jump, out_csr_wen}, 6'b0);
`ifdef DECODE_SCHED_ILLEGAL_TRAP_EN
    chk("ill_flag", out_illegal, 1'b1);
`else
    chk("ill_flag", out_illegal, 1'b0);
    chk("ill_nop_sel", out_imm_sel, 3'd0);
`endif

    // Reset mid-stream
    in_valid = 1'b1; in_inst = 32'h00500093;
    tick();
    chk("mr_valid_before", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mr_out_valid", out_valid, 1'b0);
    chk("mr_stall_cnt", stall_cnt, '0);
    chk("mr_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1 chk("mr_ready_after", in_ready, 1'b1);
    tick();
    chk("mr_first_valid", out_valid, 1'b1);
    chk("mr_first_inst", out_inst, 32'h00500093);
    in_valid = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/decode_sched.md
Name: decode_sched

Overview:
- Decode-stage controller between instruction fetch and execute.
- Accepts instructions over a valid/ready handshake and decodes the opcode into the 3-bit immediate-select code that drives the immediate generator, plus register and memory control fields.
- Holds the result in a single output pipeline register.
- Inserts a one-cycle bubble on load-use hazards, honours a synchronous flush, and counts hazard stall cycles.

Parameters:
- CNT_W, 32, width of the stall-cycle counter; saturates at all-ones.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  block accepts the instruction this cycle.
- in_inst  in  32  raw instruction word.
- flush  in  1  discard the held and incoming instruction (branch/jump redirect).
- out_valid  out  1  decoded instruction held.
- out_ready  in  1  execute consumes the held instruction.
- out_inst  out  32  registered instruction word, fed to the immediate generator.
- out_imm_sel  out  3  I=000, S=001, B=010, J=011, U=100, C=101 (CSR zimm).
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_reg_wen, out_mem_rd, out_mem_wr, out_branch, out_jump, out_csr_wen  out  1 each  control flags.
- out_illegal  out  1  unrecognised opcode (see Optional Feature).
- stall_cnt  out  CNT_W  number of hazard-stall cycles.

Behaviour:
- Reset (asynchronous, immediate):
  - out_valid=0, all out_* fields=0, stall_cnt=0.
  - in_ready=0 while rst is high.
- Opcode to imm_sel:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111 -> I.
  - STORE 0100011 -> S. BRANCH 1100011 -> B. JAL 1101111 -> J. LUI 0110111 and AUIPC 0010111 -> U.
  - OP 0110011 -> I (unused downstream).
  - SYSTEM 1110011 -> C when funct3[2]=1, otherwise I.
- Control flags:
  - reg_wen for LOAD, OP-IMM, OP, LUI, AUIPC, JAL, JALR, and SYSTEM with funct3!=0. reg_wen is forced 0 when rd=0.
  - mem_rd for LOAD; mem_wr for STORE; branch for BRANCH; jump for JAL and JALR; csr_wen for SYSTEM with funct3!=0.
- Source usage (combinational, for hazard detection):
  - uses_rs1 for everything except LUI, AUIPC, JAL and CSR immediate forms.
  - uses_rs2 for OP, STORE and BRANCH.
- Hazard:
  - hazard = out_valid & out_mem_rd & out_rd!=0 & ((uses_rs1 & in rs1==out_rd) | (uses_rs2 & in rs2==out_rd)).
  - It is evaluated on in_inst only when in_valid=1.
- Handshake:
  - in_ready = (!out_valid | out_ready) & !hazard & !flush & !rst.
  - Accept = in_valid & in_ready; on accept the register loads the decoded fields next edge with out_valid=1. Latency is 1 cycle.
  - out_valid & out_ready & !accept -> out_valid=0 next edge (empties the register, or inserts the bubble).
  - out_valid & !out_ready -> register holds all fields stable.
- Load-use bubble:
  - Load held and consumer arriving: in_ready=0.
  - When execute takes the load, the register empties. The consumer is accepted the next cycle, which gives exactly one bubble.
- Flush:
  - out_valid=0 next edge regardless of out_ready; in_ready=0 in the flush cycle; the incoming instruction is dropped.
  - Flush takes priority over accept and over hazard.
- stall_cnt: increments on each cycle with in_valid & hazard & !flush; saturates at 2^CNT_W-1.
- Simultaneous out_ready and accept: the register is replaced in the same edge, with no bubble.

Optional Feature:
- Macro: DECODE_SCHED_ILLEGAL_TRAP_EN.
- Defined: an unlisted opcode, or inst[1:0]!=11, sets out_illegal=1 and forces reg_wen, mem_rd, mem_wr, branch, jump and csr_wen to 0. The instruction still flows through the handshake.
- Undefined: out_illegal is tied 0 and unlisted opcodes decode as a NOP (imm_sel=I, all flags 0).

Decomposition:
- Shared package: opcode localparams, the imm_sel codes (I/S/B/J/U/C, matching the immediate generator's encoding), and the funct3 CSR constants.
- One combinational sub-module, decode_sched_dec: instruction -> imm_sel, flags, uses_rs1, uses_rs2, illegal.
- Registers, handshake, hazard logic and counter stay in decode_sched.

Test Plan:
- Reset mid-stream: assert rst with out_valid=1 -> out_valid=0, stall_cnt=0 immediately; in_ready=1 the first cycle after release when in_valid=1.
- Type sweep: feed 0x00500093 (addi), 0x00112023 (sw), 0x00208463 (beq), 0x008000EF (jal), 0x12345037 (lui), 0x3400D073 (csrrwi) -> out_imm_sel 000, 001, 010, 011, 100, 101 one cycle after accept; flags match the decode rules.
- Load-use: lw x5,0(x1) then add x6,x5,x2 with out_ready=1 -> exactly one out_valid=0 cycle between them; stall_cnt=1. Same pair with rd=x0 -> no bubble.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable. Raise out_ready -> next instruction appears the following cycle.
- Flush: flush=1 while holding a valid instruction and presenting a new one -> out_valid=0 next cycle; the new instruction is never output.
- With DECODE_SCHED_ILLEGAL_TRAP_EN, feed 0x0000007F -> out_illegal=1 and all enables 0. Without the macro -> out_illegal=0 and a NOP decode.
